pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register for the processor datapath. It generalises the fixed-width inter-stage registers (IF/ID … MEM/WB) into one reusable block. Additions over those registers: valid/ready flow control, back-pressure stalls, synchronous flush for bubble insertion, an optional skid slot that breaks the ready path, and saturating stall/bubble counters for performance analysis. One instance sits between each pair of pipeline stages.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_stage_reg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the handshaked pipeline stage register.
//   state_e       - occupancy of a stage (empty, head only, head + skid)
//   XLEN/RA_W/OPC_W - default payload field widths
//   payload_t     - packed payload record at the default widths
//   payload_width - flattened payload width for arbitrary field widths
package pipe_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OPC_W = 6;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  rdata2;
        logic [RA_W-1:0]  rd;
        logic [OPC_W-1:0] opcode;
    } payload_t;

    function automatic int unsigned payload_width(input int unsigned xlen,
                                                  input int unsigned ra_w,
                                                  input int unsigned opc_w);
        return 4 * xlen + ra_w + opc_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with synchronous clear and load.
//   clk     - clock
//   rst     - synchronous active-high reset, zeroes the register
//   load_i  - capture d_i on the next edge
//   clear_i - zero the register on the next edge (wins over load_i)
//   d_i     - payload in
//   q_o     - registered payload out
module pipe_slot #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (clear_i) begin
            data_d = '0;
        end else if (load_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional skid slot,
// synchronous flush and saturating stall/bubble counters.
//   clk, rst            - clock, synchronous active-high reset
//   flush               - squash all held entries
//   in_valid/in_ready   - upstream handshake; in_* payload
//   out_valid/out_ready - downstream handshake; out_* payload of the head entry
//   stall_cnt           - cycles with out_valid=1, out_ready=0 (saturating)
//   bubble_cnt          - cycles with out_valid=0, out_ready=1 (saturating)
module pipe_stage_reg #(
    parameter int unsigned XLEN  = pipe_pkg::XLEN,
    parameter int unsigned RA_W  = pipe_pkg::RA_W,
    parameter int unsigned OPC_W = pipe_pkg::OPC_W,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_alu,
    input  logic [XLEN-1:0]  in_rdata2,
    input  logic [RA_W-1:0]  in_rd,
    input  logic [OPC_W-1:0] in_opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_alu,
    output logic [XLEN-1:0]  out_rdata2,
    output logic [RA_W-1:0]  out_rd,
    output logic [OPC_W-1:0] out_opcode,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    import pipe_pkg::*;

    localparam int unsigned PW = payload_width(XLEN, RA_W, OPC_W);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic          accept, release_w;
    logic          head_load, skid_load, head_from_skid;
    logic [PW-1:0] in_pl, head_d, head_q, skid_q;

    assign in_pl = {in_instr, in_pc, in_alu, in_rdata2, in_rd, in_opcode};

    // SKID=1 takes in_ready from a register so out_ready never reaches upstream
    // combinationally; only flush gates it directly.
    assign in_ready  = (SKID != 0) ? (rdy_q & ~flush)
                                   : ((~out_valid_q | out_ready) & ~flush);
    assign accept    = in_valid & in_ready;
    assign release_w = out_valid_q & out_ready;

    // With SKID=0 an accept in StOne always coincides with a release, so StTwo
    // is unreachable and the same next-state logic serves both modes.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StOne;
                        head_load = 1'b1;
                    end
                end
                StOne: begin
                    if (accept && !release_w) begin
                        state_d   = StTwo;
                        skid_load = 1'b1;
                    end else if (release_w && !accept) begin
                        state_d = StEmpty;
                    end else if (accept) begin
                        head_load = 1'b1;
                    end
                end
                StTwo: begin
                    if (release_w) begin
                        state_d        = StOne;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign out_valid_d = (state_d != StEmpty);
    assign rdy_d       = (state_d != StTwo);
    assign head_d      = head_from_skid ? skid_q : in_pl;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (out_valid_q && !out_ready && (stall_q != CntMax)) begin
            stall_d = stall_q + 1'b1;
        end
        if (!out_valid_q && out_ready && (bubble_q != CntMax)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            stall_q     <= '0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            rdy_q       <= rdy_d;
            stall_q     <= stall_d;
            bubble_q    <= bubble_d;
        end
    end

    pipe_slot #(
        .Width (PW)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .load_i  (head_load),
        .clear_i (flush),
        .d_i     (head_d),
        .q_o     (head_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(
            .Width (PW)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load_i  (skid_load),
            .clear_i (flush),
            .d_i     (in_pl),
            .q_o     (skid_q)
        );
    end else begin : g_no_skid
        logic unused_skid_load;
        assign unused_skid_load = skid_load;
        assign skid_q           = '0;
    end

    assign {out_instr, out_pc, out_alu, out_rdata2, out_rd, out_opcode} = head_q;
    assign out_valid  = out_valid_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
